fifo_umbral: RTL and testbench



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_umbral_if.sv | 30 +++
 rtl/fifo_mem.sv | 29 ++
 rtl/fifo_umbral.sv | 119 +++++++++++
 tb/tb_fifo_umbral.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_umbral: error-state encoding and the depth derivation.
package fifo_pkg;

    typedef enum logic [1:0] {
        ERR_OK        = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } err_state_t;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Request/response bundle of one fifo_umbral queue: thresholds, push/pop, data and status flags.
interface fifo_umbral_if #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 2
) ();

    logic [ADDR_WIDTH-1:0] umbral_alto;
    logic [ADDR_WIDTH-1:0] umbral_bajo;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  error;

    modport master (
        output umbral_alto, umbral_bajo, push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty, error
    );

    modport slave (
        input  umbral_alto, umbral_bajo, push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty, error
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents are intentionally not reset; occupancy is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    err_state_t            r_err_state;
    err_state_t            w_err_next;
    logic                  r_error;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == CW'(0));
    // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
    assign w_wr_acc = bus.push && (!w_full || bus.pop);
    assign w_rd_acc = bus.pop && !w_empty;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = w_mem_rdata;
    assign bus.valid_out = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= w_mem_rdata;
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
`endif

    // Thresholds are live inputs, so these flags track them without a register stage.
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= (CW'(DEPTH) - CW'(bus.umbral_alto)));
    assign bus.almost_empty = (r_count <= CW'(bus.umbral_bajo));
    assign bus.error        = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_state <= ERR_OK;
            r_error     <= 1'b0;
        end else begin
            r_err_state <= w_err_next;
            r_error     <= (w_err_next != ERR_OK);
        end
    end

    // First error wins; both error states are sticky until reset.
    always_comb begin
        w_err_next = r_err_state;
        case (r_err_state)
            ERR_OK: begin
                if (bus.push && w_full && !bus.pop) begin
                    w_err_next = ERR_OVERFLOW;
                end else if (bus.pop && w_empty) begin
                    w_err_next = ERR_UNDERFLOW;
                end
            end
            default: w_err_next = r_err_state;
        endcase
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// Scoreboard bench for fifo_umbral (registered-read build): queue-based reference model plus random traffic.
module tb_fifo_umbral;

    localparam int DEPTH = 4;

    typedef struct {
        logic       valid;
        logic [5:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fifo_umbral_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus_if ();

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    exp_t       exp_q[$];
    logic [5:0] mq[$];
    int         m_err;
    logic [5:0] m_last;
    int         ua, ub;
    int         a_ua, a_ub;
    int         checks, errors;
    bit         started;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_flags();
        int n;
        n = mq.size();
        check("full",         32'(bus_if.full),         32'(n == DEPTH));
        check("empty",        32'(bus_if.empty),        32'(n == 0));
        check("almost_full",  32'(bus_if.almost_full),  32'(n >= DEPTH - a_ua));
        check("almost_empty", 32'(bus_if.almost_empty), 32'(n <= a_ub));
        check("error",        32'(bus_if.error),        32'(m_err != 0));
    endfunction

    // One clock of stimulus: check the state left by the previous edge, drive, advance the model.
    task automatic step(input bit p, input logic [5:0] d, input bit q, input bit rst);
        exp_t e;
        int   n;
        bit   rd, wr;
        @(negedge clk);
        if (started) check_flags();
        reset              = rst;
        bus_if.push        = p;
        bus_if.data_in     = d;
        bus_if.pop         = q;
        bus_if.umbral_alto = 2'(ua);
        bus_if.umbral_bajo = 2'(ub);
        a_ua = ua;
        a_ub = ub;
        if (rst) begin
            mq.delete();
            m_err   = 0;
            m_last  = '0;
            e.valid = 1'b0;
            e.data  = '0;
            started = 1'b1;
        end else begin
            n  = mq.size();
            rd = q && (n != 0);
            wr = p && ((n != DEPTH) || q);
            if (m_err == 0) begin
                if (p && n == DEPTH && !q) m_err = 1;
                else if (q && n == 0)      m_err = 2;
            end
            if (rd) m_last = mq.pop_front();
            e.valid = rd;
            e.data  = m_last;
            if (wr) mq.push_back(d);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 6'h00, 1'b0, 1'b0);
    endtask

    // Output monitor: consumes one expectation per clock after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("valid_out", 32'(bus_if.valid_out), 32'(e.valid));
                check("data_out",  32'(bus_if.data_out),  32'(e.data));
            end else if (started) begin
                check("valid_out_idle", 32'(bus_if.valid_out), 32'(0));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] vals [4];
        bus_if.push = 1'b0; bus_if.pop = 1'b0; bus_if.data_in = '0;
        bus_if.umbral_alto = '0; bus_if.umbral_bajo = '0;
        checks = 0; errors = 0; started = 1'b0;
        vals[0] = 6'h11; vals[1] = 6'h22; vals[2] = 6'h33; vals[3] = 6'h04;

        // Fill to full, drain in order
        ua = 1; ub = 0;
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, vals[i], 0, 0);
        step(1, vals[3], 0, 0);
        check("dir_af_at3", 32'(bus_if.almost_full), 32'(1));
        check("dir_full_at3", 32'(bus_if.full), 32'(0));
        idle();
        check("dir_full_at4", 32'(bus_if.full), 32'(1));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        idle();
        check("dir_empty_drained", 32'(bus_if.empty), 32'(1));

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(1, 6'(8'h05 + 8'(i * 7)), 0, 0);
            step(0, 0, 1, 0);
        end
        idle();
        check("dir_wrap_noerr", 32'(bus_if.error), 32'(0));

        // Overflow, then underflow must not displace it
        for (int i = 0; i < 4; i++) step(1, 6'(i + 1), 0, 0);
        step(1, 6'h3F, 0, 0);
        idle();
        check("dir_ovf_err", 32'(bus_if.error), 32'(1));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        idle();
        check("dir_ovf_sticky", 32'(bus_if.error), 32'(1));

        // Empty push+pop: underflow, word readable next cycle
        step(0, 0, 0, 1);
        step(1, 6'h2A, 1, 0);
        idle();
        check("dir_unf_err", 32'(bus_if.error), 32'(1));
        check("dir_unf_cnt1", 32'(bus_if.empty), 32'(0));
        step(0, 0, 1, 0);
        idle();

        // Full push+pop: no error, occupancy unchanged
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 6'(i + 9), 0, 0);
        step(1, 6'h15, 1, 0);
        idle();
        check("dir_fullpp_full", 32'(bus_if.full), 32'(1));
        check("dir_fullpp_noerr", 32'(bus_if.error), 32'(0));

        // almost_empty sweep with umbral_bajo=2, then reset with data inside
        ub = 2;
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 6'(i + 20), 0, 0);
        step(0, 0, 1, 0);
        idle();
        check("dir_ae_cnt3", 32'(bus_if.almost_empty), 32'(0));
        step(0, 0, 0, 1);
        idle();
        check("dir_rst_empty", 32'(bus_if.empty), 32'(1));
        check("dir_rst_noerr", 32'(bus_if.error), 32'(0));

        // Random traffic with moving thresholds and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ((i % 8) == 0) begin
                ua = int'($urandom_range(0, 3));
                ub = int'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 99) < 55), 6'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 299) == 0));
        end
        idle();
        idle();
        @(negedge clk);
        check_flags();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
